// File: rtl/alu_mutant_scanner.sv
`default_nettype none
// ============================================================================
// Module      : alu_mutant_scanner
// Description : Exhaustive {opcode,A,B} sweep driver and golden-model checker
//               for the 4-bit ALU family and its mutants.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mutant_scanner #(
    parameter int STOP_ON_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  dut_A,
    output logic [3:0]  dut_B,
    output logic [2:0]  dut_opcode,
    input  logic [3:0]  dut_result,
    input  logic        dut_zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] err_count,
    output logic [10:0] first_fail_vec,
    output logic [3:0]  first_fail_result,
    output logic        first_fail_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [10:0] c_LAST_VEC = 11'h7FF;

    state_t      state_q;
    logic [10:0] vec_q;
    logic [11:0] err_q;
    logic [11:0] err_d;
    logic [10:0] ffv_q;
    logic [3:0]  ffr_q;
    logic        ffz_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;

    logic [2:0]  w_op;
    logic [3:0]  w_a;
    logic [3:0]  w_b;
    logic [3:0]  w_gold;
    logic        w_gold_zero;
    logic        w_mismatch;
    logic        w_stop;

    assign w_op = vec_q[10:8];
    assign w_a  = vec_q[7:4];
    assign w_b  = vec_q[3:0];

    always_comb begin
        w_gold = 4'h0;
        case (w_op)
            3'd0:    w_gold = w_a + w_b;
            3'd1:    w_gold = w_a - w_b;
            3'd2:    w_gold = w_a & w_b;
            3'd3:    w_gold = w_a | w_b;
            3'd4:    w_gold = w_a ^ w_b;
            3'd5:    w_gold = (w_a == w_b) ? 4'd1 : 4'd0;
            3'd6:    w_gold = (w_a < w_b) ? 4'd1 : 4'd0;
            default: w_gold = 4'h0;
        endcase
    end

    assign w_gold_zero = (w_gold == 4'h0);
    assign w_mismatch  = (dut_result != w_gold) || (dut_zero != w_gold_zero);
    assign err_d       = err_q + {11'd0, w_mismatch};
    assign w_stop      = (vec_q == c_LAST_VEC) || ((STOP_ON_FIRST != 0) && w_mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= 11'd0;
            err_q   <= 12'd0;
            ffv_q   <= 11'd0;
            ffr_q   <= 4'd0;
            ffz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        vec_q   <= 11'd0;
                        err_q   <= 12'd0;
                        ffv_q   <= 11'd0;
                        ffr_q   <= 4'd0;
                        ffz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    err_q <= err_d;
                    // A zero error count before this compare marks the first failure
                    if (w_mismatch && (err_q == 12'd0)) begin
                        ffv_q <= vec_q;
                        ffr_q <= dut_result;
                        ffz_q <= dut_zero;
                    end
                    if (w_stop) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 12'd0);
                    end else begin
                        vec_q <= vec_q + 11'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_opcode        = vec_q[10:8];
    assign dut_A             = vec_q[7:4];
    assign dut_B             = vec_q[3:0];
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign err_count         = err_q;
    assign first_fail_vec    = ffv_q;
    assign first_fail_result = ffr_q;
    assign first_fail_zero   = ffz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mutant_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mutant_scanner
// Description : Directed bench driving two scanners (run-all and stop-on-first)
//               against a selectable fault-injected ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mutant_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    int   fault;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  a0, b0, r0, a1, b1, r1;
    logic [2:0]  op0, op1;
    logic        z0, z1;
    logic        busy0, done0, pass0, ffz0;
    logic        busy1, done1, pass1, ffz1;
    logic [11:0] err0, err1;
    logic [10:0] ffv0, ffv1;
    logic [3:0]  ffr0, ffr1;

    // fault: 0 none, 1 operand A bit 2 inverted, 2 NOP returns 0001
    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input int flt);
        logic [3:0] aa;
        aa = (flt == 1) ? (a ^ 4'h4) : a;
        case (op)
            3'd0:    return aa + b;
            3'd1:    return aa - b;
            3'd2:    return aa & b;
            3'd3:    return aa | b;
            3'd4:    return aa ^ b;
            3'd5:    return (aa == b) ? 4'd1 : 4'd0;
            3'd6:    return (aa < b) ? 4'd1 : 4'd0;
            default: return (flt == 2) ? 4'd1 : 4'd0;
        endcase
    endfunction

    always_comb begin
        r0 = alu_f(op0, a0, b0, fault);
        z0 = (r0 == 4'h0);
        r1 = alu_f(op1, a1, b1, fault);
        z1 = (r1 == 4'h0);
    end

    alu_mutant_scanner #(.STOP_ON_FIRST(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_A(a0), .dut_B(b0), .dut_opcode(op0),
        .dut_result(r0), .dut_zero(z0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_result(ffr0), .first_fail_zero(ffz0)
    );

    alu_mutant_scanner #(.STOP_ON_FIRST(1)) u_dut_stop (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dut_A(a1), .dut_B(b1), .dut_opcode(op1),
        .dut_result(r1), .dut_zero(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_result(ffr1), .first_fail_zero(ffz1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy0"}, {31'd0, busy0}, 0);
        check({tag, " done0"}, {31'd0, done0}, 0);
        check({tag, " pass0"}, {31'd0, pass0}, 0);
        check({tag, " err0"}, {20'd0, err0}, 0);
        check({tag, " vec0"}, {21'd0, op0, a0, b0}, 0);
        check({tag, " ff0"}, {16'd0, ffv0, ffr0, ffz0}, 0);
        check({tag, " out1"}, {busy1, done1, pass1, err1, ffv1, ffr1, ffz1, op1, a1, b1}, 0);
    endtask

    // Pulses start, optionally re-pulses at busy cycle start_at or resets at rst_at
    task automatic sweep(input int start_at, input int rst_at, output int cyc0, output int cyc1);
        bit finished;
        finished = 1'b0;
        cyc0 = 0;
        cyc1 = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            if (busy0) cyc0++;
            if (busy1) cyc1++;
            start = (start_at != 0) && (cyc0 == start_at);
            if (rst_at != 0 && cyc0 == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("midreset");
                @(negedge clk);
                rst_n = 1'b1;
                finished = 1'b1;
                break;
            end
            if (done0 && !busy1) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("sweep_timeout", {31'd0, finished}, 1);
    endtask

    int c0, c1;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        fault = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy0}, 0);

        // Fault-free ALU
        sweep(0, 0, c0, c1);
        check("clean_cycles", c0, 2048);
        check("clean_done", {31'd0, done0}, 1);
        check("clean_pass", {31'd0, pass0}, 1);
        check("clean_err", {20'd0, err0}, 0);
        check("clean_ffv", {21'd0, ffv0}, 0);
        check("clean_hold_vec", {21'd0, op0, a0, b0}, 32'h7FF);
        check("clean_stop_cycles", c1, 2048);
        check("clean_stop_pass", {31'd0, pass1}, 1);

        // A[2] inverted
        fault = 1;
        sweep(0, 0, c0, c1);
        check("a2_cycles", c0, 2048);
        check("a2_err", {20'd0, err0}, 1120);
        check("a2_pass", {31'd0, pass0}, 0);
        check("a2_ffv", {21'd0, ffv0}, 32'h000);
        check("a2_ffr", {28'd0, ffr0}, 4);
        check("a2_ffz", {31'd0, ffz0}, 0);
        check("a2_stop_cycles", c1, 1);
        check("a2_stop_done", {31'd0, done1}, 1);
        check("a2_stop_err", {20'd0, err1}, 1);
        check("a2_stop_ffv", {21'd0, ffv1}, 32'h000);
        check("a2_stop_pass", {31'd0, pass1}, 0);

        // Restart from DONE with a fault-free ALU
        fault = 0;
        sweep(0, 0, c0, c1);
        check("restart_cycles", c0, 2048);
        check("restart_err", {20'd0, err0}, 0);
        check("restart_pass", {31'd0, pass0}, 1);
        check("restart_ff", {16'd0, ffv0, ffr0, ffz0}, 0);
        check("restart_stop_err", {20'd0, err1}, 0);

        // NOP returns 0001
        fault = 2;
        sweep(0, 0, c0, c1);
        check("nop_err", {20'd0, err0}, 256);
        check("nop_ffv", {21'd0, ffv0}, 32'h700);
        check("nop_ffr", {28'd0, ffr0}, 1);
        check("nop_ffz", {31'd0, ffz0}, 0);
        check("nop_pass", {31'd0, pass0}, 0);
        check("nop_stop_cycles", c1, 32'h701);
        check("nop_stop_ffv", {21'd0, ffv1}, 32'h700);
        check("nop_stop_hold_vec", {21'd0, op1, a1, b1}, 32'h700);

        // Start pulse during RUN is ignored
        fault = 0;
        sweep(50, 0, c0, c1);
        check("ignore_start_cycles", c0, 2048);
        check("ignore_start_pass", {31'd0, pass0}, 1);

        // Reset mid-sweep, then a clean full sweep
        sweep(0, 100, c0, c1);
        check("after_rst_idle", {30'd0, busy0, done0}, 0);
        sweep(0, 0, c0, c1);
        check("post_rst_cycles", c0, 2048);
        check("post_rst_err", {20'd0, err0}, 0);
        check("post_rst_pass", {31'd0, pass0}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mutant_scanner.md
Name: alu_mutant_scanner

Overview:
Sequential exhaustive stimulus driver and response checker for the 4-bit combinational ALU family, including its fault-injected mutants. It sweeps every {opcode, A, B} combination into the ALU under test and compares the ALU's result and zero flag against an internal golden model. It counts mismatches and records the first failing vector. It sits in the mutation-testing harness as the active end of the ALU interface: it drives A/B/opcode and consumes result/zero_flag.

Parameters:
STOP_ON_FIRST, 0, when 1 the sweep ends on the first mismatch; when 0 all 2048 vectors are run

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a sweep from IDLE or DONE
dut_A  output  4  operand A to ALU under test
dut_B  output  4  operand B to ALU under test
dut_opcode  output  3  opcode to ALU under test
dut_result  input  4  ALU result (combinational from dut_* outputs)
dut_zero  input  1  ALU zero_flag
busy  output  1  high while sweep in progress
done  output  1  high from sweep end until next start
pass  output  1  valid when done: 1 iff err_count==0
err_count  output  12  number of mismatching vectors (max 2048, no saturation needed)
first_fail_vec  output  11  {opcode,A,B} of first mismatch; 0 if none
first_fail_result  output  4  dut_result captured at first mismatch
first_fail_zero  output  1  dut_zero captured at first mismatch

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and all outputs to 0, including the vector index. Reset mid-sweep abandons the sweep; no partial results are retained.
- Vector index vec[10:0] = {opcode,A,B}, B least significant. It is registered and drives dut_* directly, so dut_opcode=vec[10:8], dut_A=vec[7:4], dut_B=vec[3:0].
- Golden model, computed on vec, all arithmetic mod 16:
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND, 011 OR, 100 XOR: bitwise
  - 101 EQ: 1 if A==B, else 0
  - 110 LT: unsigned, 1 if A<B, else 0
  - 111 NOP: 0
  - golden zero = (golden result == 0)
- Mismatch when dut_result != golden result OR dut_zero != golden zero.
- FSM: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 -> RUN with vec=0, err_count=0, first_fail_* cleared.
  - RUN: busy=1. One vector per cycle; dut_* are stable for the whole cycle and dut outputs are sampled at the closing edge (one-cycle latency from vec to compare).
  - On that edge:
    - if mismatch: err_count+1; if first mismatch, capture vec, dut_result and dut_zero into first_fail_*.
    - if vec==2047, or (STOP_ON_FIRST and mismatch) -> DONE; else vec+1.
  - RUN start is ignored.
  - DONE: busy=0, done=1, pass=(err_count==0). Results hold. dut_* hold the last applied vector. start=1 -> RUN with all counters cleared (same as from IDLE).
- A full sweep is exactly 2048 busy cycles; done rises on the edge after the 2048th compare.
- start coincident with rst_n low: reset wins.

Test Plan:
- Fault-free ALU, STOP_ON_FIRST=0, start pulse -> busy for exactly 2048 cycles, then done=1, pass=1, err_count=0, first_fail_vec=0.
- ALU with A[2] inverted, STOP_ON_FIRST=0 -> err_count=1120 (ADD 256, SUB 256, AND 128, OR 128, XOR 256, EQ 32, LT 64, NOP 0), pass=0, first_fail_vec=0x000, first_fail_result=4, first_fail_zero=0.
- Same fault, STOP_ON_FIRST=1 -> done after 1 busy cycle, err_count=1, first_fail_vec=0x000.
- ALU mutant whose NOP returns 0001 -> err_count=256, first_fail_vec=0x700, first_fail_result=1, first_fail_zero=0.
- Start pulse at RUN cycle 50 is ignored (sweep still 2048 cycles). rst_n low at RUN cycle 100 -> all outputs 0 immediately; a new start gives a clean full sweep.
- Second start from DONE after the faulty run, now with a fault-free ALU -> counters cleared; done with pass=1, err_count=0.
